alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single combinational ALU among NREQ requesters (e.g. the execute stage and the multiply/divide helper). It accepts one operation at a time over a valid/ready handshake, drives registered operands and opcode into the ALU, captures ALURes and Zero, and returns them to the granted requester over a second valid/ready handshake. It also screens divide-by-zero so the ALU never evaluates an undefined quotient.

---
 rtl/alu_arbiter_if.sv | 28 ++
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the shared-ALU arbiter: request and response handshakes.
// Requester i owns slice [i*DW +: DW] of the operand buses and bit i of every strobe.
interface alu_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ*5-1:0]  req_shamt;
  logic [NREQ*5-1:0]  req_op;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [DW-1:0]      rsp_res;
  logic               rsp_zero;
  logic               rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_shamt, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_shamt, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU among NREQ requesters.
// Latency: accept at edge 0, result valid from cycle 2 (cycle 1 for divide-by-zero).
// Backpressure: result held in RESP until the granted rsp_ready; no accept outside IDLE.
module alu_arbiter #(
  parameter int         NREQ      = 2,
  parameter int         DW        = 32,
  parameter logic [4:0] ALUOP_DIV = 5'd12
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  rq,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [4:0]    alu_shamt,
  output logic [4:0]    alu_op,
  input  logic [DW-1:0] alu_res,
  input  logic          alu_zero,
  output logic          busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nx;
  logic [PW-1:0]   g_reg;
  logic [PW-1:0]   gnt;
  logic [PW:0]     idx;
  logic            any_vld;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic [4:0]      sel_shamt;
  logic [4:0]      sel_op;
  logic            div_zero;
  logic            accept;
  logic            rsp_done;
  logic [NREQ-1:0] req_ready_c;
  logic [NREQ-1:0] rsp_valid_c;
  logic [DW-1:0]   rsp_res_q;
  logic            rsp_zero_q;
  logic            rsp_err_q;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    gnt     = ptr;
    any_vld = 1'b0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) begin
        idx = idx - (PW+1)'(NREQ);
      end
      if (rq.req_valid[idx[PW-1:0]]) begin
        gnt     = idx[PW-1:0];
        any_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a     = rq.req_a[int'(gnt)*DW +: DW];
    sel_b     = rq.req_b[int'(gnt)*DW +: DW];
    sel_shamt = rq.req_shamt[int'(gnt)*5 +: 5];
    sel_op    = rq.req_op[int'(gnt)*5 +: 5];
  end

  assign div_zero = (sel_op == ALUOP_DIV) && (sel_b == '0);
  assign accept   = (state == IDLE) && any_vld;
  assign rsp_done = (state == RESP) && rq.rsp_ready[g_reg];
  assign ptr_nx   = (g_reg == PW'(NREQ - 1)) ? '0 : g_reg + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_vld) state_nx = div_zero ? RESP : EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rq.rsp_ready[g_reg]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // req_ready is masked during reset so a pending request never sees a strobe.
  always_comb begin
    req_ready_c = '0;
    rsp_valid_c = '0;
    if (rst_n && (state == IDLE) && any_vld) begin
      req_ready_c[gnt] = 1'b1;
    end
    if (state == RESP) begin
      rsp_valid_c[g_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      g_reg      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_shamt  <= '0;
      alu_op     <= '0;
      rsp_res_q  <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        g_reg <= gnt;
        // A zero divisor never reaches the ALU; the ALU keeps its previous operands.
        if (div_zero) begin
          rsp_res_q  <= '0;
          rsp_zero_q <= 1'b1;
          rsp_err_q  <= 1'b1;
        end else begin
          alu_a     <= sel_a;
          alu_b     <= sel_b;
          alu_shamt <= sel_shamt;
          alu_op    <= sel_op;
        end
      end
      if (state == EXEC) begin
        rsp_res_q  <= alu_res;
        rsp_zero_q <= alu_zero;
        rsp_err_q  <= 1'b0;
      end
      if (rsp_done) begin
        ptr <= ptr_nx;
      end
    end
  end

  assign rq.req_ready = req_ready_c;
  assign rq.rsp_valid = rsp_valid_c;
  assign rq.rsp_res   = rsp_res_q;
  assign rq.rsp_zero  = rsp_zero_q;
  assign rq.rsp_err   = rsp_err_q;
  assign busy         = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU model and a response scoreboard.
module tb_alu_arbiter;
  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam logic [4:0] OP_SLL = 5'd0;
  localparam logic [4:0] OP_OR  = 5'd1;
  localparam logic [4:0] OP_ADD = 5'd2;
  localparam logic [4:0] OP_SUB = 5'd6;
  localparam logic [4:0] OP_DIV = 5'd12;

  typedef struct packed {
    logic [1:0]  vld;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [4:0]  alu_shamt, alu_op;
  logic        alu_zero, busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  int   rsp_cnt[2];
  int   gseq[$];

  alu_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  alu_arbiter #(.NREQ(NREQ), .DW(DW), .ALUOP_DIV(OP_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .rq(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_op(alu_op),
    .alu_res(alu_res), .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(logic [4:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_OR:   return a | b;
      OP_SLL:  return b << sh;
      OP_DIV:  return (b != 0) ? a / b : 32'hDEADBEEF;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_res  = alu_f(alu_op, alu_a, alu_b, alu_shamt);
    alu_zero = (alu_res == 32'd0);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop one expected result for every completed response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
      if (bus.rsp_valid[0]) rsp_cnt[0]++;
      if (bus.rsp_valid[1]) rsp_cnt[1]++;
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_rsp_valid", 32'(bus.rsp_valid), 32'(e.vld));
        chk("sb_rsp_res", bus.rsp_res, e.res);
        chk("sb_rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
        chk("sb_rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [4:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    bus.req_op[i*5 +: 5]    = op;
    bus.req_shamt[i*5 +: 5] = sh;
    bus.req_a[i*32 +: 32]   = a;
    bus.req_b[i*32 +: 32]   = b;
    bus.req_valid[i]        = 1'b1;
  endtask

  // Returns at the negedge on which req_ready[i] is seen; n counts idle cycles before it.
  task automatic wait_accept(int i, string tag, output int n);
    @(negedge clk);
    for (n = 0; n < 30 && bus.req_ready[i] !== 1'b1; n++) @(negedge clk);
    chk({tag, "_accept_in_time"}, 32'(n < 30), 32'd1);
  endtask

  task automatic drain(string tag);
    int n;
    for (n = 0; n < 30 && (sbq.size() != 0 || busy !== 1'b0); n++) @(negedge clk);
    chk({tag, "_drain"}, 32'(n < 30), 32'd1);
    tick();
  endtask

  task automatic run_both(int nper);
    int cnt[2];
    int n;
    cnt = '{0, 0};
    gseq.delete();
    bus.req_valid = 2'b11;
    for (n = 0; n < 60 && bus.req_valid != 2'b00; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (bus.req_ready[i] === 1'b1) begin
          gseq.push_back(i);
          cnt[i]++;
        end
      end
      tick();
      for (int i = 0; i < 2; i++) if (cnt[i] >= nper) bus.req_valid[i] = 1'b0;
    end
    chk("both_in_time", 32'(n < 60), 32'd1);
  endtask

  task automatic chk_all_zero(string p);
    chk({p, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({p, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({p, "_rsp_res"}, bus.rsp_res, 32'd0);
    chk({p, "_rsp_zero"}, 32'(bus.rsp_zero), 32'd0);
    chk({p, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({p, "_alu_a"}, alu_a, 32'd0);
    chk({p, "_alu_b"}, alu_b, 32'd0);
    chk({p, "_alu_shamt"}, 32'(alu_shamt), 32'd0);
    chk({p, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({p, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid = 2'b01;
    bus.req_a = '0; bus.req_b = '0; bus.req_shamt = '0; bus.req_op = '0;
    bus.rsp_ready = 2'b00;
    rsp_cnt = '{0, 0};
    #12;
    chk_all_zero("reset");
    bus.req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();

    // Single ADD from requester 0: accept in cycle 0, EXEC in 1, result in 2.
    bus.rsp_ready = 2'b11;
    set_req(0, OP_ADD, 32'd5, 32'd7, 5'd0);
    sbq.push_back('{vld: 2'b01, res: 32'd12, zero: 1'b0, err: 1'b0});
    wait_accept(0, "add", n);
    chk("add_accept_cycle", 32'(n), 32'd0);
    tick();
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    chk("add_exec_busy", 32'(busy), 32'd1);
    chk("add_exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("add_rsp_cycle2", 32'(bus.rsp_valid), 32'd1);
    tick();

    // Divide by zero from requester 1: result in cycle 1, ALU registers untouched.
    set_req(1, OP_DIV, 32'd100, 32'd0, 5'd0);
    sbq.push_back('{vld: 2'b10, res: 32'd0, zero: 1'b1, err: 1'b1});
    wait_accept(1, "div0", n);
    chk("div0_accept_cycle", 32'(n), 32'd0);
    tick();
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    chk("div0_rsp_cycle1", 32'(bus.rsp_valid), 32'd2);
    chk("div0_alu_op_kept", 32'(alu_op), 32'(OP_ADD));
    chk("div0_alu_b_kept", alu_b, 32'd7);
    tick();

    // Contention: both held valid, grants must alternate starting at requester 0.
    rsp_cnt = '{0, 0};
    set_req(0, OP_ADD, 32'd1, 32'd2, 5'd0);
    set_req(1, OP_SUB, 32'd10, 32'd3, 5'd0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) sbq.push_back('{vld: 2'b01, res: 32'd3, zero: 1'b0, err: 1'b0});
      else            sbq.push_back('{vld: 2'b10, res: 32'd7, zero: 1'b0, err: 1'b0});
    end
    run_both(2);
    drain("cont");
    chk("cont_grant_count", 32'(gseq.size()), 32'd4);
    for (int k = 0; k < 4 && k < gseq.size(); k++) chk("cont_grant_order", 32'(gseq[k]), 32'(k % 2));
    chk("cont_rsp_cnt0", 32'(rsp_cnt[0]), 32'd2);
    chk("cont_rsp_cnt1", 32'(rsp_cnt[1]), 32'd2);

    // Backpressure: SUB 9-9 held for 4 cycles; requester 1 waits, rsp_ready[1] ignored.
    bus.rsp_ready = 2'b10;
    set_req(0, OP_SUB, 32'd9, 32'd9, 5'd0);
    sbq.push_back('{vld: 2'b01, res: 32'd0, zero: 1'b1, err: 1'b0});
    wait_accept(0, "bp", n);
    tick();
    bus.req_valid[0] = 1'b0;
    set_req(1, OP_ADD, 32'h100, 32'h23, 5'd0);
    sbq.push_back('{vld: 2'b10, res: 32'h123, zero: 1'b0, err: 1'b0});
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_res_held", bus.rsp_res, 32'd0);
      chk("bp_rsp_zero_held", 32'(bus.rsp_zero), 32'd1);
      chk("bp_no_grant", 32'(bus.req_ready), 32'd0);
    end
    tick();
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_no_grant_at_done", 32'(bus.req_ready), 32'd0);
    wait_accept(1, "bp_next", n);
    chk("bp_next_accept_cycle", 32'(n), 32'd0);
    tick();
    bus.req_valid[1] = 1'b0;
    drain("bp");

    // Shift: SLL of b=3 by 4.
    set_req(0, OP_SLL, 32'd0, 32'h3, 5'd4);
    sbq.push_back('{vld: 2'b01, res: 32'h30, zero: 1'b0, err: 1'b0});
    wait_accept(0, "sll", n);
    tick();
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    chk("sll_alu_shamt", 32'(alu_shamt), 32'd4);
    chk("sll_alu_op", 32'(alu_op), 32'(OP_SLL));
    drain("sll");

    // Reset during EXEC of an OR from requester 1 (round-robin pointer is 1 here).
    set_req(1, OP_OR, 32'hF0, 32'h0F, 5'd0);
    wait_accept(1, "or", n);
    tick();
    set_req(0, OP_ADD, 32'd1, 32'd1, 5'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    sbq.push_back('{vld: 2'b01, res: 32'd2, zero: 1'b0, err: 1'b0});
    sbq.push_back('{vld: 2'b10, res: 32'hFF, zero: 1'b0, err: 1'b0});
    run_both(1);
    drain("postrst");
    chk("postrst_grant_count", 32'(gseq.size()), 32'd2);
    if (gseq.size() > 0) chk("postrst_first_grant", 32'(gseq[0]), 32'd0);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
